// File: rtl/bus_pkg.sv
// Shared definitions for the tri-state bus controllers: arbiter state encoding
// and a one-hot helper sized for the widest supported requester count.
package bus_pkg;

   localparam int unsigned MAX_REQ = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } bus_state_e;

   function automatic logic [MAX_REQ-1:0] onehot(input logic [3:0] idx);
      logic [MAX_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request bit after last_i, wrapping
// modulo NUM_REQ, so the previous winner has the lowest priority.
module rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    last_i,
   output logic               found_o,
   output logic [ID_W-1:0]    sel_o
);

   always_comb begin
      found_o = 1'b0;
      sel_o   = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         if (!found_o && req_i[(32'(last_i) + i) % NUM_REQ]) begin
            found_o = 1'b1;
            sel_o   = ID_W'((32'(last_i) + i) % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin tri-state bus arbiter with max-hold limit and a dead window between
// owners. Define BUS_ARB_LOCK_EN to let the owner's lock bit suppress the max-hold release.
module bus_arbiter_rr
   import bus_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned MAX_HOLD   = 8,
   parameter int unsigned TURNAROUND = 1,
   parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] done,
   input  logic [NUM_REQ-1:0] lock,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    owner_id,
   output logic               bus_busy,
   output logic               turnaround
);

   bus_state_e         state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [ID_W-1:0]    owner_q, owner_d;
   logic [ID_W-1:0]    last_q,  last_d;
   logic [7:0]         hold_q,  hold_d;
   logic [3:0]         turn_q,  turn_d;

   logic               pick_found;
   logic [ID_W-1:0]    pick_sel;
   logic               lock_hold;
   logic               release_now;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req_i   (req),
      .last_i  (last_q),
      .found_o (pick_found),
      .sel_o   (pick_sel)
   );

`ifdef BUS_ARB_LOCK_EN
   assign lock_hold = lock[owner_q];
`else
   logic unused_lock;
   assign unused_lock = ^lock;
   assign lock_hold   = 1'b0;
`endif

   assign release_now = !req[owner_q] || done[owner_q] ||
                        ((hold_q == 8'(MAX_HOLD)) && !lock_hold);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      last_d  = last_q;
      hold_d  = hold_q;
      turn_d  = turn_q;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = GRANT;
               grant_d = NUM_REQ'(onehot(4'(pick_sel)));
               owner_d = pick_sel;
               last_d  = pick_sel;
               hold_d  = 8'd1;
            end
         end
         GRANT: begin
            if (release_now) begin
               state_d = TURN;
               grant_d = '0;
               owner_d = '0;
               hold_d  = '0;
               turn_d  = 4'd1;
            end else if (hold_q != 8'(MAX_HOLD)) begin
               hold_d = hold_q + 8'd1;
            end
         end
         TURN: begin
            // Last dead cycle re-arbitrates directly so the window is exactly TURNAROUND long.
            if (turn_q < 4'(TURNAROUND)) begin
               turn_d = turn_q + 4'd1;
            end else begin
               turn_d = '0;
               if (pick_found) begin
                  state_d = GRANT;
                  grant_d = NUM_REQ'(onehot(4'(pick_sel)));
                  owner_d = pick_sel;
                  last_d  = pick_sel;
                  hold_d  = 8'd1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         owner_q <= '0;
         last_q  <= ID_W'(NUM_REQ - 1);
         hold_q  <= '0;
         turn_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         turn_q  <= turn_d;
      end
   end

   assign grant      = grant_q;
   assign owner_id   = owner_q;
   assign bus_busy   = |grant_q;
   assign turnaround = (state_q == TURN);

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: two instances (MAX_HOLD/TURNAROUND 8/1 and 4/3) driven
// together, checked every cycle against an ownership model plus directed literals.
module tb_bus_arbiter_rr;

   localparam int N = 4;
`ifdef BUS_ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = '0, done = '0, lock = '0;
   logic [3:0] g0, g1;
   logic [1:0] o0, o1;
   logic       b0, b1, t0, t1;

   bus_arbiter_rr #(.NUM_REQ(4), .MAX_HOLD(8), .TURNAROUND(1)) dut0 (
      .clk(clk), .rst(rst), .req(req), .done(done), .lock(lock),
      .grant(g0), .owner_id(o0), .bus_busy(b0), .turnaround(t0));

   bus_arbiter_rr #(.NUM_REQ(4), .MAX_HOLD(4), .TURNAROUND(3)) dut1 (
      .clk(clk), .rst(rst), .req(req), .done(done), .lock(lock),
      .grant(g1), .owner_id(o1), .bus_busy(b1), .turnaround(t1));

   always #5 clk = ~clk;

   int vectors = 0, miscompares = 0;
   int m_own[2], m_held[2], m_dead[2], m_last[2];
   int mh[2] = '{8, 4};
   int ta[2] = '{1, 3};
   bit started = 1'b0;
   logic [3:0] prev_g[2] = '{4'b0, 4'b0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Ownership model: who holds the bus, for how long, and how deep into the dead window.
   function automatic void model_step(input int k);
      bit got;
      int d;
      if (rst) begin
         m_own[k] = -1; m_held[k] = 0; m_dead[k] = 0; m_last[k] = N - 1;
      end else if (m_own[k] >= 0) begin
         if (!req[m_own[k]] || done[m_own[k]] ||
             (m_held[k] >= mh[k] && !(LOCK_EN && lock[m_own[k]]))) begin
            m_own[k] = -1; m_held[k] = 0; m_dead[k] = 1;
         end else if (m_held[k] < mh[k]) begin
            m_held[k]++;
         end
      end else if (m_dead[k] > 0 && m_dead[k] < ta[k]) begin
         m_dead[k]++;
      end else begin
         m_dead[k] = 0;
         got = 1'b0;
         for (int i = 1; i <= N; i++) begin
            d = (m_last[k] + i) % N;
            if (!got && req[d]) begin
               got = 1'b1; m_own[k] = d; m_last[k] = d; m_held[k] = 1;
            end
         end
      end
   endfunction

   always @(posedge clk) begin
      model_step(0);
      model_step(1);
      started = 1'b1;
   end

   task automatic cmp(input int k, input logic [3:0] g, input logic [1:0] o,
                      input logic b, input logic t);
      logic [3:0] eg;
      eg = (m_own[k] >= 0) ? 4'(1 << m_own[k]) : 4'b0;
      chk($sformatf("model_grant%0d", k), 32'(g), 32'(eg));
      chk($sformatf("model_owner%0d", k), 32'(o), (m_own[k] >= 0) ? 32'(m_own[k]) : 0);
      chk($sformatf("model_busy%0d", k), 32'(b), 32'(m_own[k] >= 0));
      chk($sformatf("model_turn%0d", k), 32'(t), 32'(m_dead[k] > 0));
      chk($sformatf("inv_onehot%0d", k), 32'($countones(g) <= 1), 1);
      chk($sformatf("inv_busy_vs_turn%0d", k), 32'(b && t), 0);
      chk($sformatf("inv_owner_switch%0d", k),
          32'((prev_g[k] != 0) && (g != 0) && (g != prev_g[k])), 0);
      prev_g[k] = g;
   endtask

   always @(negedge clk) begin
      if (started) begin
         cmp(0, g0, o0, b0, t0);
         cmp(1, g1, o1, b1, t1);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      logic [3:0] e;

      // Reset state
      rst = 1'b1;
      repeat (2) tick();
      chk("rst_grant", 32'(g0), 0);
      chk("rst_owner", 32'(o0), 0);
      chk("rst_busy", 32'(b0), 0);
      chk("rst_turn", 32'(t0), 0);
      chk("rst_grant1", 32'(g1), 0);
      rst = 1'b0;
      tick();
      chk("idle_grant", 32'(g0), 0);

      // Single requester, early drop after 3 cycles
      req = 4'b0001;
      tick();
      chk("single_grant", 32'(g0), 32'h1);
      chk("single_owner", 32'(o0), 0);
      tick(); tick();
      req = 4'b0000;
      tick();
      chk("drop_grant", 32'(g0), 0);
      chk("drop_turn", 32'(t0), 1);
      tick();
      chk("drop_idle_turn", 32'(t0), 0);
      chk("drop_idle_grant", 32'(g0), 0);

      // All requesting: rotation 0,1,2,3,0 with fixed hold and dead window
      rst = 1'b1; tick(); rst = 1'b0;
      req = 4'b1111;
      for (int c = 1; c <= 40; c++) begin
         tick();
         e = (((c - 1) % 9) < 8) ? 4'(1 << (((c - 1) / 9) % 4)) : 4'b0;
         chk($sformatf("rot8_c%0d", c), 32'(g0), 32'(e));
         e = (((c - 1) % 7) < 4) ? 4'(1 << (((c - 1) / 7) % 4)) : 4'b0;
         chk($sformatf("rot4_c%0d", c), 32'(g1), 32'(e));
      end

      // done: non-owner bit ignored, owner bit releases
      rst = 1'b1; tick(); rst = 1'b0;
      req = 4'b0100;
      tick();
      chk("done_own", 32'(g0), 32'h4);
      done = 4'b0001;
      tick();
      chk("done_nonowner", 32'(g0), 32'h4);
      done = 4'b0000;
      tick();
      chk("done_hold3", 32'(g0), 32'h4);
      done = 4'b0100;
      tick();
      done = 4'b0000;
      chk("done_release", 32'(g0), 0);
      chk("done_turn", 32'(t0), 1);
      chk("done_release1", 32'(g1), 0);

      // Reset mid-grant
      rst = 1'b1; tick(); rst = 1'b0;
      req = 4'b0010;
      tick();
      chk("midrst_pre", 32'(g0), 32'h2);
      rst = 1'b1;
      req = 4'b0011;
      tick();
      chk("midrst_grant", 32'(g0), 0);
      chk("midrst_turn", 32'(t0), 0);
      chk("midrst_owner", 32'(o0), 0);
      rst = 1'b0;
      tick();
      chk("midrst_first", 32'(g0), 32'h1);

      // Lock on owner 1 with device 0 also requesting
      req = 4'b0000;
      rst = 1'b1; tick(); rst = 1'b0;
      req = 4'b0010;
      lock = 4'b0010;
      tick();
      chk("lock_start", 32'(g0), 32'h2);
      req = 4'b0011;
`ifdef BUS_ARB_LOCK_EN
      for (int c = 0; c < 20; c++) begin
         tick();
         chk($sformatf("lock_hold_c%0d", c), 32'(g0), 32'h2);
      end
      lock = 4'b0000;
      tick();
`else
      len = 1;
      while (len < 40) begin
         tick();
         if (g0 == 4'b0010) len++;
         else break;
      end
      chk("hold_len", 32'(len), 8);
`endif
      chk("lock_release", 32'(g0), 0);
      chk("lock_release_turn", 32'(t0), 1);
      tick();
      chk("lock_next", 32'(g0), 32'h1);
      lock = 4'b0000;
      req = 4'b0000;

      // Randomized traffic against the model
      rst = 1'b1; tick(); rst = 1'b0;
      repeat (3000) begin
         for (int b = 0; b < N; b++)
            if ($urandom_range(7) == 0) req[b] = ~req[b];
         done = ($urandom_range(15) == 0) ? 4'($urandom) : 4'b0;
         if ($urandom_range(19) == 0) lock = 4'($urandom);
         rst  = ($urandom_range(299) == 0);
         tick();
      end
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Round-robin arbiter for the shared tri-state data bus.
- Takes bus requests from NUM_REQ devices and issues a one-hot, registered grant that drives the bufif1 enables directly.
- Enforces a maximum hold time per grant.
- Inserts a dead (turnaround) window between owners so tri-state drivers turn off before the next driver turns on; this prevents bus contention.

Parameters:
- NUM_REQ, 4, number of requesting devices (2..16).
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the bus (1..255).
- TURNAROUND, 1, idle cycles with no grant between owners; must cover the max bufif1 turnoff delay (1..15).
- ID_W, $clog2(NUM_REQ), width of the owner index.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-device request level; held high while the device wants the bus.
- done  input  NUM_REQ  per-device single-cycle early release; only the owner's bit is honoured.
- lock  input  NUM_REQ  per-device hold-extension request; used only with BUS_ARB_LOCK_EN.
- grant  output  NUM_REQ  one-hot or zero, registered; drives the tri-state enables.
- owner_id  output  ID_W  index of the current owner; 0 when no grant.
- bus_busy  output  1  high whenever grant != 0.
- turnaround  output  1  high during the dead window.

Behaviour:
- Clocking and reset: one clock domain, clk. rst is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, grant=0, owner_id=0, bus_busy=0, turnaround=0, hold_cnt=0, turn_cnt=0, rr pointer last=NUM_REQ-1 (so device 0 wins first).
- States: IDLE, GRANT, TURN.
- IDLE:
  - If req != 0, select the first set bit searching last+1, last+2, ... with wrap modulo NUM_REQ.
  - Next cycle: grant=onehot(sel), owner_id=sel, last=sel, hold_cnt=1, state=GRANT. Latency from req to grant is 1 cycle.
  - If req == 0, remain in IDLE with outputs at 0.
- GRANT release: release when any of the following holds, evaluated each cycle:
  - req[owner]==0, or
  - done[owner]==1, or
  - hold_cnt==MAX_HOLD.
- GRANT on release: next cycle grant=0, owner_id=0, turnaround=1, turn_cnt=1, state=TURN.
- GRANT otherwise: hold_cnt increments, saturating at MAX_HOLD.
- Maximum hold: the owner holds grant for at most MAX_HOLD consecutive cycles.
- done on a non-owner bit: ignored.
- TURN:
  - While turn_cnt < TURNAROUND, increment turn_cnt.
  - When turn_cnt == TURNAROUND, arbitrate exactly as in IDLE from the same-cycle req.
  - If any req is set, go directly to GRANT (turnaround=0, grant set); otherwise go to IDLE.
  - The dead window is therefore exactly TURNAROUND cycles.
- Fairness: the previous owner gets lowest priority. A device still requesting after forced release regains the bus only if no other device requests.
- Invariants:
  - grant is never more than one-hot.
  - grant is never non-zero in two consecutive cycles with different owners.
  - bus_busy == |grant.
  - turnaround and bus_busy are never both high.
- Reset mid-operation: an asserted grant drops to 0 on the reset edge. No turnaround is inserted; the system reset also clears the drivers.
- req changing mid-grant: changes on non-owner bits have no effect until the next arbitration point.

Optional Feature:
- Macro: BUS_ARB_LOCK_EN.
- Defined:
  - While lock[owner]==1 and req[owner]==1, the MAX_HOLD release is suppressed (hold_cnt stays saturated).
  - Release then occurs only on a req drop or done.
  - lock on non-owners is ignored.
- Undefined:
  - The lock port remains present but is ignored.
  - MAX_HOLD is always enforced.

Decomposition:
- Shared package bus_pkg:
  - state enum for IDLE/GRANT/TURN (2-bit encoding);
  - helper function onehot(idx).
- One natural sub-module, rr_pick:
  - combinational rotate/priority-find that takes req and last and returns found and sel.
  - It is reusable by other bus controllers.

Test Plan:
- Reset, then req=4'b0001 -> grant=0001 one cycle later, owner_id=0. Drop req after 3 cycles -> grant=0 next cycle, turnaround=1 for 1 cycle, then IDLE.
- req=4'b1111 held constant, MAX_HOLD=8 -> grants go 0,1,2,3,0, each exactly 8 cycles long, separated by exactly 1 turnaround cycle each.
- Owner 2 holding, done=4'b0100 at hold_cnt=3 -> grant=0 next cycle. done=4'b0001 pulsed while device 2 owns -> no effect.
- Mid-grant assertion of rst with grant=0010 -> grant=0, state IDLE on the next edge. After rst deasserts with req=0011 -> device 0 is granted first.
- TURNAROUND=3, req=4'b0011 -> exactly 3 grant-free cycles between owners. Over the whole run the checker sees no cycle with two grant bits set.
- With BUS_ARB_LOCK_EN, owner 1 holds lock=0010 and req=0011 for 20 cycles -> grant stays 0010 for 20 cycles. When lock drops -> release on the next cycle and device 0 is granted after turnaround. Without the macro, release occurs at 8 cycles.
